// File: rtl/rv_sram_arbiter.sv
// rv_sram_arbiter: shares the SRAM driver port between instruction fetch and data.
// Define RV_SRAM_ARB_TIMEOUT_EN to abort transactions stalled for TIMEOUT_CYCLES.
module rv_sram_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              busy_o,
  output logic              timeout_o
);

  if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_param
    $error("rv_sram_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       grant_i;
  logic       grant_d;
  logic       expire;
  logic       done;
  logic       own_i;
  logic       own_d;

  assign grant_i = instr_req_i &
                   (~data_req_i | (streak == STREAK_MAX));
  assign grant_d = data_req_i & ~grant_i;

  assign own_i = (state == BUSY_I);
  assign own_d = (state == BUSY_D);
  assign done  = (own_i | own_d) & (mem_rvalid_i | expire);

`ifdef RV_SRAM_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] tcnt;

  // A real response in the expiry cycle wins over the abort.
  assign expire = (own_i | own_d) & ~mem_rvalid_i &
                  (tcnt == TO_LAST);

  // Count BUSY cycles; IDLE holds it at zero so each grant starts fresh.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tcnt <= '0;
    end else if (state == IDLE) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 10'd1;
    end
  end

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      timeout_o <= 1'b0;
    end else if (expire) begin
      timeout_o <= 1'b1;
    end
  end
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Responses route straight through to whichever port owns the bus.
  assign instr_rvalid_o = own_i & (mem_rvalid_i | expire);
  assign data_rvalid_o  = own_d & (mem_rvalid_i | expire);
  assign instr_rdata_o  = (own_i & mem_rvalid_i) ? mem_rdata_i : '0;
  assign data_rdata_o   = (own_d & mem_rvalid_i) ? mem_rdata_i : '0;

  // Arbitrate in IDLE, hold the latched request through BUSY.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      busy_o      <= 1'b0;
      streak      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_i: begin
              state       <= BUSY_I;
              mem_req_o   <= 1'b1;
              busy_o      <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_be_o    <= '1;
              mem_addr_o  <= instr_addr_i;
              mem_wdata_o <= '0;
              streak      <= '0;
            end
            grant_d: begin
              state       <= BUSY_D;
              mem_req_o   <= 1'b1;
              busy_o      <= 1'b1;
              mem_we_o    <= data_we_i;
              mem_be_o    <= data_be_i;
              mem_addr_o  <= data_addr_i;
              mem_wdata_o <= data_wdata_i;
              if (!instr_req_i) begin
                streak <= '0;
              end else if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            busy_o    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_sram_arbiter.sv
// tb_rv_sram_arbiter: directed and randomized checks of rv_sram_arbiter
// against a transaction-level reference model.
module tb_rv_sram_arbiter;

  localparam int XLEN = 32;
  localparam int MAXS = 4;
  localparam int TOC  = 8;

  logic              clk_i = 1'b0;
  logic              arstn_i = 1'b0;
  logic              instr_req_i = 1'b0;
  logic [XLEN-1:0]   instr_addr_i = '0;
  logic              instr_rvalid_o;
  logic [XLEN-1:0]   instr_rdata_o;
  logic              data_req_i = 1'b0;
  logic              data_we_i = 1'b0;
  logic [XLEN/8-1:0] data_be_i = '0;
  logic [XLEN-1:0]   data_addr_i = '0;
  logic [XLEN-1:0]   data_wdata_i = '0;
  logic              data_rvalid_o;
  logic [XLEN-1:0]   data_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_rvalid_i = 1'b0;
  logic [XLEN-1:0]   mem_rdata_i = '0;
  logic              busy_o;
  logic              timeout_o;

  always #5 clk_i = ~clk_i;

  rv_sram_arbiter #(
    .XLEN(XLEN),
    .MAX_DATA_STREAK(MAXS),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk_i(clk_i),
    .arstn_i(arstn_i),
    .instr_req_i(instr_req_i),
    .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i),
    .data_we_i(data_we_i),
    .data_be_i(data_be_i),
    .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus (0 none, 1 instr, 2 data), data grants
  // given in a row while instr waited, latched request, abort flag.
  int          m_owner;
  int          m_run;
  int          m_bcnt;
  bit          m_to;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;

  int    cnt_i;
  int    cnt_d;
  string dlog;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_run   = 0;
    m_bcnt  = 0;
    m_to    = 0;
    m_we    = 0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  // Called just after a falling edge with inputs applied; checks
  // outputs, advances the model and returns at the next falling edge.
  task automatic step();
    logic expire;
    logic done;
    logic [31:0] exp_rd;
    #1;
    expire = 1'b0;
`ifdef RV_SRAM_ARB_TIMEOUT_EN
    expire = (m_owner != 0) && !mem_rvalid_i && (m_bcnt + 1 == TOC);
`endif
    done   = (m_owner != 0) && (mem_rvalid_i || expire);
    exp_rd = (done && mem_rvalid_i) ? mem_rdata_i : 32'h0;
    chk("mem_req", mem_req_o, m_owner != 0);
    chk("busy", busy_o, m_owner != 0);
    if (m_owner != 0) begin
      chk("mem_we", mem_we_o, m_we);
      chk("mem_be", mem_be_o, m_be);
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    chk("i_rvalid", instr_rvalid_o, done && m_owner == 1);
    chk("i_rdata", instr_rdata_o, (m_owner == 1) ? exp_rd : 32'h0);
    chk("d_rvalid", data_rvalid_o, done && m_owner == 2);
    chk("d_rdata", data_rdata_o, (m_owner == 2) ? exp_rd : 32'h0);
    chk("timeout", timeout_o, m_to);
    if (instr_rvalid_o === 1'b1) begin
      cnt_i++;
      dlog = {dlog, "I"};
    end
    if (data_rvalid_o === 1'b1) begin
      cnt_d++;
      dlog = {dlog, "D"};
    end
    if (m_owner != 0) begin
      if (done) begin
        if (expire) m_to = 1;
        m_owner = 0;
      end else begin
        m_bcnt++;
      end
    end else if (instr_req_i && (!data_req_i || m_run >= MAXS)) begin
      m_owner = 1;
      m_run   = 0;
      m_bcnt  = 0;
      m_we    = 0;
      m_be    = 4'hF;
      m_addr  = instr_addr_i;
      m_wdata = 0;
    end else if (data_req_i) begin
      m_owner = 2;
      m_run   = instr_req_i ? m_run + 1 : 0;
      m_bcnt  = 0;
      m_we    = data_we_i;
      m_be    = data_be_i;
      m_addr  = data_addr_i;
      m_wdata = data_wdata_i;
    end
    @(negedge clk_i);
  endtask

  bit ipend;
  bit dpend;
  int lat;
  int lcnt;
  int resp;
  int bc;

  initial begin
    model_reset();
    cnt_i = 0;
    cnt_d = 0;
    dlog  = "";

    // Reset values
    @(negedge clk_i);
    #1;
    chk("rst mem_req", mem_req_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst mem_we", mem_we_o, 0);
    chk("rst mem_be", mem_be_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst mem_wdata", mem_wdata_o, 0);
    chk("rst timeout", timeout_o, 0);
    chk("rst rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    @(negedge clk_i);
    arstn_i = 1'b1;

    // Single data write, SRAM answers 3 cycles after mem_req_o
    data_req_i   = 1;
    data_we_i    = 1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h100;
    data_wdata_i = 32'hA5A5_0001;
    step();
    #1;
    chk("wr mem_req", mem_req_o, 1);
    chk("wr mem_addr", mem_addr_o, 32'h100);
    chk("wr mem_wdata", mem_wdata_o, 32'hA5A5_0001);
    chk("wr mem_be", mem_be_o, 4'hF);
    chk("wr mem_we", mem_we_o, 1);
    step();
    step();
    step();
    mem_rvalid_i = 1;
    mem_rdata_i  = 32'h1234_5678;
    #1;
    chk("wr d_rvalid", data_rvalid_o, 1);
    chk("wr i_rvalid", instr_rvalid_o, 0);
    step();
    data_req_i   = 0;
    mem_rvalid_i = 0;
    step();
    chk("wr d_count", cnt_d, 1);
    chk("wr i_count", cnt_i, 0);

    // Single instruction fetch
    instr_req_i  = 1;
    instr_addr_i = 32'h40;
    step();
    #1;
    chk("if mem_we", mem_we_o, 0);
    chk("if mem_be", mem_be_o, 4'hF);
    chk("if mem_addr", mem_addr_o, 32'h40);
    mem_rvalid_i = 1;
    mem_rdata_i  = 32'h0000_0013;
    #1;
    chk("if i_rvalid", instr_rvalid_o, 1);
    chk("if i_rdata", instr_rdata_o, 32'h13);
    chk("if d_rvalid", data_rvalid_o, 0);
    step();
    instr_req_i  = 0;
    mem_rvalid_i = 0;
    step();

    // Both requesters held high: grant order with streak limit
    dlog         = "";
    instr_req_i  = 1;
    instr_addr_i = 32'h80;
    data_req_i   = 1;
    data_we_i    = 0;
    data_be_i    = 4'h3;
    data_addr_i  = 32'h200;
    data_wdata_i = 32'h0;
    for (int c = 0; c < 60 && dlog.len() < 10; c++) begin
      mem_rvalid_i = (m_owner != 0);
      mem_rdata_i  = $urandom;
      step();
    end
    instr_req_i  = 0;
    data_req_i   = 0;
    mem_rvalid_i = 0;
    n_tests++;
    if (dlog != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL grant_order: got %s expected DDDDIDDDDI", dlog);
    end
    step();

    // Reset in the middle of BUSY_D
    data_req_i  = 1;
    data_we_i   = 1;
    data_addr_i = 32'h300;
    step();
    mem_rvalid_i = 1;
    arstn_i      = 0;
    #1;
    chk("arst mem_req", mem_req_o, 0);
    chk("arst busy", busy_o, 0);
    chk("arst d_rvalid", data_rvalid_o, 0);
    chk("arst i_rvalid", instr_rvalid_o, 0);
    model_reset();
    @(negedge clk_i);
    arstn_i      = 1;
    mem_rvalid_i = 0;
    step();
    mem_rvalid_i = 1;
    #1;
    chk("arst regrant", mem_req_o, 1);
    chk("arst re_addr", mem_addr_o, 32'h300);
    chk("arst re_rvalid", data_rvalid_o, 1);
    step();
    data_req_i   = 0;
    mem_rvalid_i = 0;
    step();

    // Spurious responses while IDLE
    cnt_i = 0;
    cnt_d = 0;
    mem_rvalid_i = 1;
    repeat (3) begin
      mem_rdata_i = $urandom;
      step();
    end
    mem_rvalid_i = 0;
    chk("spur rvalids", cnt_i + cnt_d, 0);
    chk("spur busy", busy_o, 0);

`ifdef RV_SRAM_ARB_TIMEOUT_EN
    // SRAM never answers: abort after TOC BUSY cycles
    cnt_d      = 0;
    data_req_i = 1;
    data_we_i  = 0;
    step();
    bc = 0;
    for (int c = 0; c < 20 && cnt_d == 0; c++) begin
      step();
      bc++;
    end
    chk("to busy_cycles", bc, TOC);
    chk("to flag", timeout_o, 1);
    data_req_i = 0;
    step();
    step();
    chk("to sticky", timeout_o, 1);
    data_req_i = 1;
    step();
    mem_rvalid_i = 1;
    mem_rdata_i  = 32'hCAFE_0000;
    #1;
    chk("to next_rdata", data_rdata_o, 32'hCAFE_0000);
    step();
    data_req_i   = 0;
    mem_rvalid_i = 0;
    step();
    chk("to next_count", cnt_d, 2);
`endif

    // Randomized traffic against the model
    ipend = 0;
    dpend = 0;
    lat   = 0;
    lcnt  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend        = 1;
        instr_addr_i = $urandom;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend        = 1;
        data_we_i    = 1'($urandom);
        data_be_i    = 4'($urandom);
        data_addr_i  = $urandom;
        data_wdata_i = $urandom;
      end
      instr_req_i = ipend;
      data_req_i  = dpend;
      if (m_owner != 0) begin
        mem_rvalid_i = (lcnt >= lat);
        lcnt++;
      end else begin
        mem_rvalid_i = ($urandom_range(0, 7) == 0);
        lcnt = 0;
        lat  = $urandom_range(0, 3);
      end
      mem_rdata_i = $urandom;
      resp = (m_owner != 0 && mem_rvalid_i) ? m_owner : 0;
      step();
      if (resp == 1) ipend = 0;
      if (resp == 2) dpend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_sram_arbiter.md
Name: rv_sram_arbiter

Overview:
- Shares the single SRAM driver port between the core instruction-fetch port and the MMU's SRAM-side data port, so code and data can both live in external SRAM.
- Forwards one transaction at a time to the SRAM driver and routes the response back to its owner.
- Fixed data-over-instruction priority, with a starvation limit that guarantees instruction progress.
- Sits between rv_core/rv_mmu and rv_sram_driver.

Parameters:
- XLEN, 32, data/address width (from rv_pkg).
- MAX_DATA_STREAK, 4, consecutive data grants allowed while an instruction request waits; range 1..15.
- TIMEOUT_CYCLES, 255, BUSY cycles before a transaction is aborted (used only with the optional feature); range 2..1023.

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  reset, asynchronous, active-low.
- instr_req_i  in  1  instruction read request (level).
- instr_addr_i  in  XLEN  instruction address.
- instr_rvalid_o  out  1  instruction response valid.
- instr_rdata_o  out  XLEN  instruction read data.
- data_req_i  in  1  data request (level).
- data_we_i  in  1  data write enable.
- data_be_i  in  XLEN/8  data byte enables.
- data_addr_i  in  XLEN  data address.
- data_wdata_i  in  XLEN  data write data.
- data_rvalid_o  out  1  data response valid (reads and writes).
- data_rdata_o  out  XLEN  data read data.
- mem_req_o  out  1  request to the SRAM driver.
- mem_we_o  out  1  write enable to the SRAM driver.
- mem_be_o  out  XLEN/8  byte enables to the SRAM driver.
- mem_addr_o  out  XLEN  address to the SRAM driver.
- mem_wdata_o  out  XLEN  write data to the SRAM driver.
- mem_rvalid_i  in  1  SRAM driver response valid.
- mem_rdata_i  in  XLEN  SRAM driver read data.
- busy_o  out  1  a transaction is in flight.
- timeout_o  out  1  sticky timeout flag.

Behaviour:
- One clock domain; reset is asynchronous, active-low on arstn_i. Clock port is clk_i, reset port is arstn_i.
- Reset values: state IDLE; all mem_* outputs 0; busy_o 0; timeout_o 0; streak counter 0; timeout counter 0.
- rvalid/rdata outputs are combinational and therefore 0 during reset.
- Requester protocol:
  - Hold req and its attributes stable until the cycle its rvalid is 1.
  - req still high in the following cycle means a new transaction.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - Only data_req_i set: latch data_* into the mem_* registers; go to BUSY_D.
  - Only instr_req_i set: latch instr_addr_i; mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0; go to BUSY_I.
  - Both set: instruction wins if streak == MAX_DATA_STREAK, otherwise data wins.
  - Neither set: stay in IDLE.
- Streak counter:
  - Increments on a data grant while instr_req_i=1.
  - Clears on an instruction grant, or on any data grant with instr_req_i=0.
  - Saturates at MAX_DATA_STREAK.
- Grant latency: the request is seen in IDLE at cycle N; mem_req_o=1 and busy_o=1 from N+1.
- mem_req_o and the latched attributes stay stable through BUSY.
- BUSY_x response:
  - When mem_rvalid_i=1, the owner's rvalid_o = 1 in the same cycle, with rdata_o = mem_rdata_i.
  - State returns to IDLE; mem_req_o and busy_o go to 0 the next cycle.
- Minimum turnaround: one IDLE cycle between back-to-back transactions.
- The non-owner's rvalid_o is always 0. rdata_o to a non-owner is 0.
- mem_rvalid_i in IDLE (spurious or late) is ignored.

Optional Feature:
- Macro: RV_SRAM_ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs in BUSY and is cleared on every grant.
  - If it reaches TIMEOUT_CYCLES without mem_rvalid_i, the owner's rvalid_o = 1 for one cycle with rdata_o = 0.
  - timeout_o sets and stays set until reset. State returns to IDLE.
  - mem_rvalid_i in the same cycle as expiry takes precedence; it is a normal completion and timeout_o is not set.
- Disabled: no counter; timeout_o is tied to 0; BUSY waits indefinitely.

Test Plan:
- Single data write addr 0x100, wdata 0xA5A5_0001, be 0xF, SRAM responds 3 cycles after mem_req_o -> mem_* match at N+1, data_rvalid_o one cycle, instr_rvalid_o stays 0.
- Single instruction fetch addr 0x40, mem_rdata_i 0x0000_0013 -> instr_rdata_o=0x13 with instr_rvalid_o; mem_we_o=0, mem_be_o=0xF.
- Both requesters held high continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; no instruction fetch waits more than 4 data transactions.
- arstn_i asserted mid-BUSY_D -> mem_req_o, busy_o, rvalid outputs 0 immediately; after release the FSM is in IDLE and re-grants cleanly.
- Spurious mem_rvalid_i while IDLE -> no rvalid to either requester, no state change.
- With RV_SRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, SRAM never responds -> data_rvalid_o pulses after 8 BUSY cycles with rdata 0; timeout_o=1 and stays set; the next request is served normally.
